// File: rtl/countdown_timer.sv
// ============================================================================
//  Module   : countdown_timer
//  Brief    : Loadable down-counter with pause, auto-reload and a one-cycle
//             terminal-count pulse. Two-state IDLE/RUN control.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module countdown_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             zero
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != c_zero) ? RUN : IDLE;
        end else if (state_q == RUN && en) begin
            if (count_q > c_one) begin
                count_d = count_q - c_one;
            end else if (count_q == c_one) begin
                tc_d = 1'b1;
                if (auto_reload) begin
                    count_d = reload_q;
                end else begin
                    count_d = c_zero;
                    state_d = IDLE;
                end
            end else begin
                // A zero count in RUN is unreachable; fall back to IDLE silently.
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= c_zero;
            reload_q <= c_zero;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == RUN);
    assign tc    = tc_q;
    assign zero  = (count_q == c_zero);

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// ============================================================================
//  Module   : tb_countdown_timer
//  Brief    : Directed, scoreboard-checked bench for countdown_timer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_countdown_timer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;
    logic             zero;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .en          (en),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .tc          (tc),
        .zero        (zero)
    );

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             bsy;
        logic             t;
        logic             z;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input logic [WIDTH-1:0] ec, input logic eb, input logic et);
        exp_t e;
        e.cnt = ec;
        e.bsy = eb;
        e.t   = et;
        e.z   = (ec == '0);
        sb_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        exp_t a;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        a.cnt = count;
        a.bsy = busy;
        a.t   = tc;
        a.z   = zero;
        assert (a === e) else begin
            n_err++;
            $error("FAIL %s: observed count=%0d busy=%b tc=%b zero=%b expected count=%0d busy=%b tc=%b zero=%b",
                   tag, a.cnt, a.bsy, a.t, a.z, e.cnt, e.bsy, e.t, e.z);
        end
    endtask

    // Drive one cycle of stimulus, expect the given outputs after the edge.
    task automatic step(input logic ld, input logic [WIDTH-1:0] lv, input logic e,
                        input logic ar, input logic [WIDTH-1:0] ec, input logic eb,
                        input logic et, input string tag);
        load        = ld;
        load_value  = lv;
        en          = e;
        auto_reload = ar;
        push_exp(ec, eb, et);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; load = 1'b0; load_value = '0; en = 1'b0; auto_reload = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push_exp(8'd0, 1'b0, 1'b0);
        check_out("reset_state");
        reset = 1'b0;

        // Idle with en high: count holds at zero.
        step(0, 0, 1, 0, 8'd0, 0, 0, "idle_en_ignored");

        // Load 3, run to terminal without reload, then stay idle.
        step(1, 3, 1, 0, 8'd3, 1, 0, "run3_load");
        step(0, 0, 1, 0, 8'd2, 1, 0, "run3_c2");
        step(0, 0, 1, 0, 8'd1, 1, 0, "run3_c1");
        step(0, 0, 1, 0, 8'd0, 0, 1, "run3_tc");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 8'd0, 0, 0, "run3_idle_hold");

        // Load 2 with auto-reload: 2,1,2,1,2,1,2 with three tc pulses.
        step(1, 2, 1, 1, 8'd2, 1, 0, "ar2_load");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 8'd1, 1, 0, "ar2_c1");
            step(0, 0, 1, 1, 8'd2, 1, 1, "ar2_reload");
        end
        step(1, 0, 0, 0, 8'd0, 0, 0, "ar2_stop");

        // auto_reload toggled before the terminal cycle has no effect.
        step(1, 2, 0, 0, 8'd2, 1, 0, "arsamp_load");
        step(0, 0, 1, 1, 8'd1, 1, 0, "arsamp_c1");
        step(0, 0, 1, 0, 8'd0, 0, 1, "arsamp_tc");

        // Pause behaviour: en 1,0,0,1,1,1 after load 4.
        step(1, 4, 0, 0, 8'd4, 1, 0, "pause_load");
        step(0, 0, 1, 0, 8'd3, 1, 0, "pause_e1");
        step(0, 0, 0, 0, 8'd3, 1, 0, "pause_e0a");
        step(0, 0, 0, 0, 8'd3, 1, 0, "pause_e0b");
        step(0, 0, 1, 0, 8'd2, 1, 0, "pause_e1b");
        step(0, 0, 1, 0, 8'd1, 1, 0, "pause_e1c");
        step(0, 0, 1, 0, 8'd0, 0, 1, "pause_tc");
        step(0, 0, 1, 0, 8'd0, 0, 0, "pause_after");

        // Load beats terminal count; load of zero goes idle with no tc.
        step(1, 1, 1, 0, 8'd1, 1, 0, "prio_load1");
        step(1, 9, 1, 1, 8'd9, 1, 0, "prio_load9");
        step(0, 0, 0, 0, 8'd9, 1, 0, "prio_hold");
        step(1, 0, 1, 0, 8'd0, 0, 0, "load0");
        step(0, 0, 1, 0, 8'd0, 0, 0, "load0_idle_a");
        step(0, 0, 1, 0, 8'd0, 0, 0, "load0_idle_b");

        // Reload value 1: tc every enabled cycle.
        step(1, 1, 1, 1, 8'd1, 1, 0, "r1_load");
        step(0, 0, 1, 1, 8'd1, 1, 1, "r1_tc_a");
        step(0, 0, 1, 1, 8'd1, 1, 1, "r1_tc_b");
        step(0, 0, 0, 1, 8'd1, 1, 0, "r1_pause");

        // Asynchronous reset mid-run, then a normal run.
        step(1, 5, 0, 0, 8'd5, 1, 0, "rst_load5");
        step(0, 0, 1, 0, 8'd4, 1, 0, "rst_c4");
        step(1, 5, 0, 0, 8'd5, 1, 0, "rst_reload5");
        #2;
        reset = 1'b1;
        #1;
        push_exp(8'd0, 1'b0, 1'b0);
        check_out("rst_async");
        @(posedge clk);
        #1;
        push_exp(8'd0, 1'b0, 1'b0);
        check_out("rst_held");
        reset = 1'b0;
        step(1, 3, 1, 0, 8'd3, 1, 0, "rst_post_load3");
        step(0, 0, 1, 0, 8'd2, 1, 0, "rst_post_c2");
        step(0, 0, 1, 0, 8'd1, 1, 0, "rst_post_c1");
        step(0, 0, 1, 0, 8'd0, 0, 1, "rst_post_tc");

        // Full-scale load: tc exactly 255 edges after load, no wrap.
        step(1, 8'hFF, 1, 0, 8'd255, 1, 0, "ff_load");
        for (int i = 1; i < 255; i++) begin
            step(0, 0, 1, 0, 8'(255 - i), 1, 0, "ff_count");
        end
        step(0, 0, 1, 0, 8'd0, 0, 1, "ff_tc");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'd0, 0, 0, "ff_no_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning counter and load-value width in bits.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, meaning the asynchronous, active-high reset.
REQ-004 The block SHALL have port load, input, 1, meaning capture load_value into count and the reload register.
REQ-005 The block SHALL have port load_value, input, WIDTH, meaning the start value, unsigned.
REQ-006 The block SHALL have port en, input, 1, meaning decrement qualifier (one decrement per cycle with en=1).
REQ-007 The block SHALL have port auto_reload, input, 1, meaning restart from the reload register at terminal count.
REQ-008 The block SHALL have port count, output, WIDTH, meaning the current counter value (registered).
REQ-009 The block SHALL have port busy, output, 1, meaning the FSM is in RUN.
REQ-010 The block SHALL have port tc, output, 1, meaning a one-cycle terminal-count pulse (registered).
REQ-011 The block SHALL have port zero, output, 1, meaning count==0 (combinational from the count register).

Function
REQ-012 The FSM SHALL have two states, IDLE and RUN, with busy=1 exactly in RUN.
REQ-013 On load=1 with load_value!=0, the block SHALL, at the next edge, set count=load_value, set reload_reg=load_value, enter RUN, and set tc=0, in any state.
REQ-014 On load=1 with load_value=0, the block SHALL set count=0, set reload_reg=0, enter IDLE, and never assert tc.
REQ-015 load SHALL have priority over en, terminal count and auto_reload in the same cycle.
REQ-016 In RUN with en=1, load=0 and count>1, the block SHALL set count=count-1 at the next edge.
REQ-017 In RUN with en=0, the block SHALL hold count and state (pause).
REQ-018 In RUN with en=1, load=0, count==1 and auto_reload=0, the block SHALL set count=0, enter IDLE, and set tc=1 for exactly one cycle.
REQ-019 In RUN with en=1, load=0, count==1 and auto_reload=1, the block SHALL set count=reload_reg, stay in RUN, and set tc=1 for one cycle.
REQ-020 auto_reload SHALL be sampled only in the terminal cycle, and changing it mid-run SHALL have no other effect.
REQ-021 Latency from load to first decrement SHALL be one cycle: count shows load_value in the cycle after load, and shows load_value-1 after the next en cycle.
REQ-022 A run of N (N>=1) with en held high SHALL produce tc exactly N cycles after the load edge.
REQ-023 count SHALL never wrap below 0; in IDLE, en SHALL be ignored and count SHALL hold.
REQ-024 tc SHALL be 0 in every cycle not immediately following a terminal-count edge, and reload with load_value=1 SHALL give tc every cycle while en=1.
REQ-025 Arithmetic SHALL be unsigned modulo-free, and a load_value of 2^WIDTH-1 SHALL count down fully without overflow.

Reset
REQ-026 While reset=1, the block SHALL asynchronously force count=0, reload_reg=0, tc=0, state=IDLE (busy=0, zero=1), independent of clk.
REQ-027 Reset asserted mid-run SHALL abort the run with no tc pulse, and the first edge after deassertion SHALL honour load/en normally.

Verification
REQ-028 The bench SHALL cover this scenario: reset pulse during count=0x05 RUN -> outputs immediately 0/IDLE/tc=0, then load 3 after release -> normal run.
REQ-029 The bench SHALL cover this scenario: load 0x03, en=1 continuously, auto_reload=0 -> count 3,2,1,0, with tc high exactly in the cycle count first reads 0, then busy=0 and count held at 0 for 5 more en cycles.
REQ-030 The bench SHALL cover this scenario: load 0x02, auto_reload=1, en=1 for 7 cycles -> count 2,1,2,1,2,1,2, with tc asserted on each transition to reload (3 pulses) and busy stays 1.
REQ-031 The bench SHALL cover this scenario: load 0x04, en toggling 1,0,0,1,1,1 -> count 4,3,3,3,2,1,0, with a single tc.
REQ-032 The bench SHALL cover this scenario: load 0x01 with en=1 in the terminal cycle of a prior run plus load=1 value 0x09 -> count=9, RUN, tc=0; and load 0x00 -> IDLE, tc never asserted.
REQ-033 The bench SHALL cover this scenario: WIDTH=8, load 0xFF, en=1 -> tc exactly 255 cycles after load, with no wrap to 0xFF afterwards.
